// File: rtl/wb_to_axi.sv
// Bridges single Wishbone classic accesses onto a 32-bit AXI4 master port.
// One access is outstanding at a time. A response with bit 1 set (SLVERR/DECERR) is reported as wb_err_o.
module wb_to_axi #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_aresetn,

    input  logic                          wb_cyc_i,
    input  logic                          wb_stb_i,
    input  logic                          wb_we_i,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]                   wb_dat_i,
    input  logic [3:0]                    wb_sel_i,
    output logic [31:0]                   wb_dat_o,
    output logic                          wb_ack_o,
    output logic                          wb_err_o,

    output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_awid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,

    output logic [31:0]                   m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,

    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,

    output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,

    input  logic [31:0]                   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDATA,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:2] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          aborted_q, aborted_d;
    logic          deliver;

    // The master must still own the cycle, and must not have released it at any point, for a pulse to be returned.
    assign deliver = wb_cyc_i && !aborted_q;

    always_comb begin
        // NOTE: every variable gets a default before the case statement, so no path can leave it unassigned and infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        aborted_d = aborted_q;

        if (state_q != IDLE && !wb_cyc_i) begin
            aborted_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_d    = wb_adr_i[AW-1:2];
                    wdata_d   = wb_dat_i;
                    wstrb_d   = wb_sel_i;
                    aborted_d = 1'b0;
                    if (wb_we_i) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        arvalid_d = 1'b1;
                    end
                end
            end

            WRITE: begin
                // Address and data channels complete independently; leave only when both have handshaken.
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end

            WRESP: begin
                if (m_axi_bvalid && bready_q) begin
                    bready_d = 1'b0;
                    state_d  = DONE;
                    ack_d    = deliver && !m_axi_bresp[1];
                    err_d    = deliver && m_axi_bresp[1];
                end
            end

            READ: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end

            RDATA: begin
                if (m_axi_rvalid && rready_q) begin
                    rready_d = 1'b0;
                    rdata_d  = m_axi_rdata;
                    state_d  = DONE;
                    ack_d    = deliver && !m_axi_rresp[1];
                    err_d    = deliver && m_axi_rresp[1];
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the pre-edge value of the others.
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    assign wb_dat_o      = rdata_q;
    assign wb_ack_o      = ack_q;
    assign wb_err_o      = err_q;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = {addr_q, 2'b00};
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;

    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = wvalid_q;

    assign m_axi_bready  = bready_q;

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = {addr_q, 2'b00};
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;

    assign m_axi_rready  = rready_q;

    // Address bits [1:0] and the EXOKAY bit of each response carry no meaning for this bridge.
    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], m_axi_bresp[0], m_axi_rresp[0]};

endmodule

// File: tb/tb_wb_to_axi.sv
// Self-checking bench for wb_to_axi: a memory-backed AXI slave with programmable stalls and responses,
// plus a word-level reference memory that predicts the Wishbone-side results.
module tb_wb_to_axi;

    localparam int AW = 32;
    localparam int IW = 1;
    localparam logic [31:0] ERR_DATA = 32'hBAD0_E77E;

    logic          m_axi_aclk = 1'b0;
    logic          m_axi_aresetn;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [AW-1:0] wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o, wb_err_o;
    logic [IW-1:0] m_axi_awid, m_axi_arid;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_arsize;
    logic [1:0]    m_axi_awburst, m_axi_arburst;
    logic          m_axi_awvalid, m_axi_awready;
    logic [31:0]   m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid, m_axi_bready;
    logic          m_axi_arvalid, m_axi_arready;
    logic [31:0]   m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rvalid, m_axi_rready;

    always #5 m_axi_aclk = ~m_axi_aclk;

    wb_to_axi #(.C_M_AXI_ID_WIDTH(IW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
        .m_axi_aclk(m_axi_aclk), .m_axi_aresetn(m_axi_aresetn),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave configuration: stall cycles per channel and the responses to return.
    int         cfg_aw_delay = 0, cfg_w_delay = 0, cfg_ar_delay = 0, cfg_b_delay = 0, cfg_r_delay = 0;
    logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;

    logic [31:0]   mem [int];
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_wstrb;
    int            b_hs_count = 0, stab_viol = 0;

    int            aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit            got_aw, got_w, got_ar, b_fire, r_fire, aw_hold, w_hold, ar_hold;
    logic [AW-1:0] hold_awaddr, hold_araddr;
    logic [35:0]   hold_w;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // AXI slave: decides readies/valids on the falling edge; a valid&ready pair seen here completes on the next rising edge.
    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
        forever begin
            @(negedge m_axi_aclk);
            if (!m_axi_aresetn) begin
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                got_aw = 0; got_w = 0; got_ar = 0; b_fire = 0; r_fire = 0;
                aw_hold = 0; w_hold = 0; ar_hold = 0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0;
                continue;
            end
            if (b_fire) begin
                m_axi_bvalid = 0; b_fire = 0; got_aw = 0; got_w = 0; b_wait = 0;
            end else if (got_aw && got_w && !m_axi_bvalid) begin
                if (b_wait >= cfg_b_delay) begin
                    m_axi_bvalid = 1; m_axi_bresp = cfg_bresp;
                end else b_wait++;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_fire = 1; b_hs_count++;
                if (!m_axi_bresp[1]) begin
                    logic [31:0] old;
                    old = mem.exists(int'(cap_awaddr >> 2)) ? mem[int'(cap_awaddr >> 2)] : 32'h0;
                    mem[int'(cap_awaddr >> 2)] = (old & ~strb_mask(cap_wstrb)) | (cap_wdata & strb_mask(cap_wstrb));
                end
            end
            if (r_fire) begin
                m_axi_rvalid = 0; r_fire = 0; got_ar = 0; r_wait = 0;
            end else if (got_ar && !m_axi_rvalid) begin
                if (r_wait >= cfg_r_delay) begin
                    m_axi_rvalid = 1; m_axi_rresp = cfg_rresp;
                    m_axi_rdata = cfg_rresp[1] ? ERR_DATA :
                                  (mem.exists(int'(cap_araddr >> 2)) ? mem[int'(cap_araddr >> 2)] : 32'h0);
                end else r_wait++;
            end
            if (m_axi_rvalid && m_axi_rready) r_fire = 1;

            if (aw_hold && (!m_axi_awvalid || m_axi_awaddr !== hold_awaddr)) stab_viol++;
            m_axi_awready = m_axi_awvalid && (aw_wait >= cfg_aw_delay);
            if (m_axi_awvalid && m_axi_awready) begin cap_awaddr = m_axi_awaddr; got_aw = 1; aw_wait = 0; end
            else if (m_axi_awvalid) aw_wait++;
            aw_hold = m_axi_awvalid && !m_axi_awready; hold_awaddr = m_axi_awaddr;

            if (w_hold && (!m_axi_wvalid || {m_axi_wstrb, m_axi_wdata} !== hold_w)) stab_viol++;
            m_axi_wready = m_axi_wvalid && (w_wait >= cfg_w_delay);
            if (m_axi_wvalid && m_axi_wready) begin
                cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; got_w = 1; w_wait = 0;
            end else if (m_axi_wvalid) w_wait++;
            w_hold = m_axi_wvalid && !m_axi_wready; hold_w = {m_axi_wstrb, m_axi_wdata};

            if (ar_hold && (!m_axi_arvalid || m_axi_araddr !== hold_araddr)) stab_viol++;
            m_axi_arready = m_axi_arvalid && (ar_wait >= cfg_ar_delay);
            if (m_axi_arvalid && m_axi_arready) begin cap_araddr = m_axi_araddr; got_ar = 1; ar_wait = 0; end
            else if (m_axi_arvalid) ar_wait++;
            ar_hold = m_axi_arvalid && !m_axi_arready; hold_araddr = m_axi_araddr;
        end
    end

    // Reference model: word memory seen through byte enables, and the last value a read returned.
    logic [31:0] ref_mem [int];
    logic [31:0] exp_dat_o = 32'h0;

    function automatic logic [31:0] ref_read(input logic [AW-1:0] adr);
        return ref_mem.exists(int'(adr[AW-1:2])) ? ref_mem[int'(adr[AW-1:2])] : 32'h0;
    endfunction

    task automatic model_write(input logic [AW-1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] v;
        v = ref_read(adr);
        for (int b = 0; b < 4; b++) if (sel[b]) v[8*b +: 8] = dat[8*b +: 8];
        ref_mem[int'(adr[AW-1:2])] = v;
    endtask

    task automatic start_access(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(negedge m_axi_aclk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        @(posedge m_axi_aclk);
    endtask

    // Holds the request until a pulse appears (bounded), then releases the bus and steps one more cycle.
    task automatic wait_done(output bit done, output logic got_ack, output logic got_err, output int lat);
        done = 0; got_ack = 0; got_err = 0; lat = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge m_axi_aclk);
            lat++;
            if (wb_ack_o || wb_err_o) begin done = 1; got_ack = wb_ack_o; got_err = wb_err_o; end
        end
        wb_cyc_i = 0; wb_stb_i = 0;
        @(negedge m_axi_aclk);
    endtask

    task automatic do_access(input string tag, input logic we, input logic [AW-1:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        bit   done;
        logic a, e, exp_err;
        int   lat, exp_lat;
        logic [31:0] exp_rd;
        exp_err = we ? cfg_bresp[1] : cfg_rresp[1];
        exp_lat = we ? 3 + ((cfg_aw_delay > cfg_w_delay) ? cfg_aw_delay : cfg_w_delay) + cfg_b_delay
                     : 3 + cfg_ar_delay + cfg_r_delay;
        start_access(we, adr, dat, sel);
        wait_done(done, a, e, lat);
        check({tag, ":done"}, done, 1);
        check({tag, ":ack"}, a, !exp_err);
        check({tag, ":err"}, e, exp_err);
        check({tag, ":latency"}, lat, exp_lat);
        check({tag, ":pulse_end"}, {wb_ack_o, wb_err_o}, 2'b00);
        if (we) begin
            check({tag, ":awaddr"}, cap_awaddr, {adr[AW-1:2], 2'b00});
            check({tag, ":wdata"}, cap_wdata, dat);
            check({tag, ":wstrb"}, cap_wstrb, sel);
            check({tag, ":dat_hold"}, wb_dat_o, exp_dat_o);
            if (!exp_err) model_write(adr, dat, sel);
        end else begin
            exp_rd = exp_err ? ERR_DATA : ref_read(adr);
            exp_dat_o = exp_rd;
            check({tag, ":araddr"}, cap_araddr, {adr[AW-1:2], 2'b00});
            check({tag, ":rdata"}, wb_dat_o, exp_rd);
        end
    endtask

    task automatic set_all_ready();
        cfg_aw_delay = 0; cfg_w_delay = 0; cfg_ar_delay = 0; cfg_b_delay = 0; cfg_r_delay = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    endtask

    initial begin
        bit          done, seen;
        logic        a, e;
        int          lat, pulses, bh0, r;
        logic [AW-1:0] adr;

        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        m_axi_aresetn = 0;
        repeat (3) @(negedge m_axi_aclk);
        #1;
        check("rst:valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
        check("rst:ack_err", {wb_ack_o, wb_err_o}, 2'b00);
        check("rst:dat_o", wb_dat_o, 32'h0);
        check("const:aw", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wlast}, {1'b0, 8'd0, 3'b010, 2'b01, 1'b1});
        check("const:ar", {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst}, {1'b0, 8'd0, 3'b010, 2'b01});
        @(negedge m_axi_aclk);
        #2 m_axi_aresetn = 1;

        set_all_ready();
        do_access("wr104", 1'b1, 32'h104, 32'hDEADBEEF, 4'hF);
        do_access("rd104", 1'b0, 32'h104, 32'h0, 4'hF);

        // Late AW ready: W completes first, AW stays up with the same address.
        cfg_aw_delay = 3;
        start_access(1'b1, 32'h20A, 32'hCAFEF00D, 4'h5);
        @(negedge m_axi_aclk);
        check("aw_late:both_valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        @(negedge m_axi_aclk);
        check("aw_late:w_dropped", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
        check("aw_late:awaddr_held", m_axi_awaddr, 32'h208);
        wait_done(done, a, e, lat);
        check("aw_late:done", done, 1);
        check("aw_late:ack_err", {a, e}, 2'b10);
        check("aw_late:latency", lat + 2, 6);
        check("aw_late:single_pulse", {wb_ack_o, wb_err_o}, 2'b00);
        check("aw_late:cap", {cap_awaddr, cap_wstrb, cap_wdata}, {32'h208, 4'h5, 32'hCAFEF00D});
        model_write(32'h208, 32'hCAFEF00D, 4'h5);
        set_all_ready();
        do_access("rd208", 1'b0, 32'h208, 32'h0, 4'hF);

        // Read answered with SLVERR.
        cfg_rresp = 2'b10;
        do_access("rd_err", 1'b0, 32'h104, 32'h0, 4'hF);
        set_all_ready();

        // Master abandons the cycle while the write response is pending.
        cfg_b_delay = 5;
        start_access(1'b1, 32'h30C, 32'h12345678, 4'hF);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge m_axi_aclk);
            if (m_axi_bready) seen = 1;
        end
        check("cyc_drop:bready_seen", seen, 1);
        wb_cyc_i = 0; wb_stb_i = 0;
        bh0 = b_hs_count; pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge m_axi_aclk);
            if (wb_ack_o || wb_err_o) pulses++;
        end
        check("cyc_drop:no_pulse", pulses, 0);
        check("cyc_drop:b_handshake", b_hs_count - bh0, 1);
        check("cyc_drop:bready_low", m_axi_bready, 0);
        model_write(32'h30C, 32'h12345678, 4'hF);
        set_all_ready();
        do_access("cyc_drop:rd", 1'b0, 32'h30C, 32'h0, 4'hF);

        // Randomized traffic over a small window of words with random stalls and responses.
        for (int n = 0; n < 40; n++) begin
            cfg_aw_delay = $urandom_range(0, 3); cfg_w_delay = $urandom_range(0, 3);
            cfg_ar_delay = $urandom_range(0, 3); cfg_b_delay = $urandom_range(0, 3);
            cfg_r_delay  = $urandom_range(0, 3);
            r = $urandom_range(0, 7);
            cfg_bresp = (r < 5) ? 2'b00 : (r == 5) ? 2'b01 : (r == 6) ? 2'b10 : 2'b11;
            r = $urandom_range(0, 7);
            cfg_rresp = (r < 5) ? 2'b00 : (r == 5) ? 2'b01 : (r == 6) ? 2'b10 : 2'b11;
            adr = 32'h100 + AW'($urandom_range(0, 7) << 2) + AW'($urandom_range(0, 3));
            do_access($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset in the middle of a stalled read.
        set_all_ready();
        do_access("pre_rst:rd", 1'b0, 32'h104, 32'h0, 4'hF);
        cfg_ar_delay = 20;
        start_access(1'b0, 32'h104, 32'h0, 4'hF);
        @(negedge m_axi_aclk);
        check("rst_rd:arvalid_up", m_axi_arvalid, 1);
        #2 m_axi_aresetn = 0;
        #1;
        check("rst_rd:valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
        check("rst_rd:ack_err", {wb_ack_o, wb_err_o}, 2'b00);
        check("rst_rd:dat_o", wb_dat_o, 32'h0);
        exp_dat_o = 32'h0;
        wb_cyc_i = 0; wb_stb_i = 0;
        @(negedge m_axi_aclk);
        @(negedge m_axi_aclk);
        #2 m_axi_aresetn = 1;
        set_all_ready();
        do_access("post_rst:wr", 1'b1, 32'h110, 32'hA5A5_5A5A, 4'hC);
        do_access("post_rst:rd", 1'b0, 32'h110, 32'h0, 4'hF);

        check("axi_payload_stability", stab_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
